// File: rtl/dlx_mc_control_fsm.sv
// Multicycle DLX control unit: state-decoded datapath controls with a memory wait/timeout counter.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to route unlisted opcodes to a TRAP state instead of R-type.
module dlx_mc_control_fsm #(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 7,
    parameter int ALUSRCB_W   = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OPCODE_W-1:0]  opCode,
    input  logic                 mem_ready,
    output logic                 PCWriteIfNonZero,
    output logic                 PCWriteIfZero,
    output logic                 PCWrite,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 ALUSrcA,
    output logic                 RegWrite,
    output logic [1:0]           MemToReg,
    output logic [1:0]           PCSource,
    output logic [1:0]           RegDst,
    output logic [ALUOP_W-1:0]   ALUOp,
    output logic [ALUSRCB_W-1:0] ALUSrcB,
    output logic [4:0]           state_o,
    output logic                 instr_done,
    output logic                 mem_timeout,
    output logic                 trap
);

    typedef enum logic [4:0] {
        FETCH = 5'd0, DECODE = 5'd1, MEM_ADDR = 5'd2, MEM_READ = 5'd3, WB_MEM = 5'd4,
        MEM_WRITE = 5'd5, R_EXEC = 5'd6, R_WB = 5'd7, I_EXEC = 5'd8, I_WB = 5'd9,
        IU_EXEC = 5'd10, LHI_WB = 5'd11, BEQZ_S = 5'd12, BNEZ_S = 5'd13, JUMP_S = 5'd14,
        JAL_S = 5'd15, JALR_S = 5'd16, JR_S = 5'd17, TRAP_S = 5'd18
    } state_t;

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t            stateReg, stateNext;
    logic [CNT_W-1:0]  waitCnt, waitNext;
    logic              memState, timeoutHit, rdyQ;

    // A request arriving while reset is held must not open IRWrite/PCWrite.
    assign rdyQ       = mem_ready & ~reset;
    assign memState   = (stateReg == FETCH) || (stateReg == MEM_READ) || (stateReg == MEM_WRITE);
    assign timeoutHit = (MEM_TIMEOUT != 0) && memState && !rdyQ &&
                        (waitCnt == CNT_W'(MEM_TIMEOUT));
    assign state_o    = stateReg;

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= FETCH;
            waitCnt  <= '0;
        end else begin
            stateReg <= stateNext;
            waitCnt  <= waitNext;
        end
    end

    // Next-state selection and wait-counter update.
    always_comb begin
        stateNext = FETCH;
        waitNext  = '0;
        case (stateReg)
            FETCH:     stateNext = rdyQ ? DECODE : (timeoutHit ? FETCH : FETCH);
            DECODE: begin
                case (opCode)
                    OPCODE_W'(6'h23), OPCODE_W'(6'h2b): stateNext = MEM_ADDR;
                    OPCODE_W'(6'h08), OPCODE_W'(6'h0d), OPCODE_W'(6'h18), OPCODE_W'(6'h1c),
                    OPCODE_W'(6'h14), OPCODE_W'(6'h1a), OPCODE_W'(6'h19), OPCODE_W'(6'h17),
                    OPCODE_W'(6'h0a), OPCODE_W'(6'h0e): stateNext = I_EXEC;
                    OPCODE_W'(6'h0c), OPCODE_W'(6'h16): stateNext = IU_EXEC;
                    OPCODE_W'(6'h0f): stateNext = LHI_WB;
                    OPCODE_W'(6'h04): stateNext = BEQZ_S;
                    OPCODE_W'(6'h05): stateNext = BNEZ_S;
                    OPCODE_W'(6'h02): stateNext = JUMP_S;
                    OPCODE_W'(6'h03): stateNext = JAL_S;
                    OPCODE_W'(6'h13): stateNext = JALR_S;
                    OPCODE_W'(6'h12): stateNext = JR_S;
                    OPCODE_W'(6'h00): stateNext = R_EXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:          stateNext = TRAP_S;
`else
                    default:          stateNext = R_EXEC;
`endif
                endcase
            end
            MEM_ADDR:  stateNext = (opCode == OPCODE_W'(6'h23)) ? MEM_READ : MEM_WRITE;
            MEM_READ:  stateNext = rdyQ ? WB_MEM : (timeoutHit ? FETCH : MEM_READ);
            MEM_WRITE: stateNext = (rdyQ || timeoutHit) ? FETCH : MEM_WRITE;
            R_EXEC:    stateNext = R_WB;
            I_EXEC:    stateNext = I_WB;
            IU_EXEC:   stateNext = I_WB;
            default:   stateNext = FETCH;
        endcase
        // Counter only survives a cycle spent waiting in the same memory state.
        if (memState && !rdyQ && !timeoutHit && (MEM_TIMEOUT != 0)) begin
            waitNext = waitCnt + CNT_W'(1'b1);
        end else begin
            waitNext = '0;
        end
    end

    // Datapath controls decoded from the current state.
    always_comb begin
        PCWriteIfNonZero = 1'b0;
        PCWriteIfZero    = 1'b0;
        PCWrite          = 1'b0;
        IorD             = 1'b0;
        MemRead          = 1'b0;
        MemWrite         = 1'b0;
        IRWrite          = 1'b0;
        ALUSrcA          = 1'b0;
        RegWrite         = 1'b0;
        MemToReg         = 2'd0;
        PCSource         = 2'd0;
        RegDst           = 2'd0;
        ALUOp            = '0;
        ALUSrcB          = '0;
        instr_done       = 1'b0;
        trap             = 1'b0;
        mem_timeout      = timeoutHit;
        case (stateReg)
            FETCH:     begin MemRead = 1'b1; ALUSrcB = ALUSRCB_W'(3'd1); IRWrite = rdyQ; PCWrite = rdyQ; end
            DECODE:    ALUSrcB = ALUSRCB_W'(3'd4);
            MEM_ADDR:  begin ALUSrcA = 1'b1; ALUSrcB = ALUSRCB_W'(3'd3); end
            MEM_READ:  begin IorD = 1'b1; MemRead = 1'b1; end
            WB_MEM:    begin RegWrite = 1'b1; MemToReg = 2'd1; instr_done = 1'b1; end
            MEM_WRITE: begin IorD = 1'b1; MemWrite = 1'b1; instr_done = rdyQ; end
            R_EXEC:    begin ALUSrcA = 1'b1; ALUOp = ALUOP_W'(2'd2); end
            R_WB:      begin RegWrite = 1'b1; RegDst = 2'd1; instr_done = 1'b1; end
            I_EXEC:    begin ALUSrcA = 1'b1; ALUSrcB = ALUSRCB_W'(3'd3); ALUOp = ALUOP_W'(2'd2); end
            IU_EXEC:   begin ALUSrcA = 1'b1; ALUSrcB = ALUSRCB_W'(3'd2); ALUOp = ALUOP_W'(2'd2); end
            I_WB:      begin RegWrite = 1'b1; instr_done = 1'b1; end
            LHI_WB:    begin RegWrite = 1'b1; MemToReg = 2'd2; instr_done = 1'b1; end
            BEQZ_S:    begin ALUSrcA = 1'b1; ALUOp = ALUOP_W'(2'd1); PCSource = 2'd1;
                             PCWriteIfZero = 1'b1; instr_done = 1'b1; end
            BNEZ_S:    begin ALUSrcA = 1'b1; ALUOp = ALUOP_W'(2'd1); PCSource = 2'd1;
                             PCWriteIfNonZero = 1'b1; instr_done = 1'b1; end
            JUMP_S:    begin PCWrite = 1'b1; PCSource = 2'd2; instr_done = 1'b1; end
            JAL_S:     begin PCWrite = 1'b1; PCSource = 2'd2; RegWrite = 1'b1; RegDst = 2'd2;
                             MemToReg = 2'd3; instr_done = 1'b1; end
            JALR_S:    begin PCWrite = 1'b1; PCSource = 2'd3; RegWrite = 1'b1; RegDst = 2'd2;
                             MemToReg = 2'd3; instr_done = 1'b1; end
            JR_S:      begin PCWrite = 1'b1; PCSource = 2'd3; instr_done = 1'b1; end
`ifdef CTRL_ILLEGAL_TRAP_EN
            TRAP_S:    begin trap = 1'b1; instr_done = 1'b1; end
`endif
            default:   instr_done = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_dlx_mc_control_fsm.sv
// Randomized self-checking bench for dlx_mc_control_fsm against an instruction-path reference model.
module tb_dlx_mc_control_fsm;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opCode;
    logic       mem_ready;
    logic       PCWriteIfNonZero, PCWriteIfZero, PCWrite, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0] MemToReg, PCSource, RegDst;
    logic [6:0] ALUOp;
    logic [2:0] ALUSrcB;
    logic [4:0] state_o;
    logic       instr_done, mem_timeout, trap;

    dlx_mc_control_fsm #(.OPCODE_W(6), .ALUOP_W(7), .ALUSRCB_W(3), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .opCode(opCode), .mem_ready(mem_ready),
        .PCWriteIfNonZero(PCWriteIfNonZero), .PCWriteIfZero(PCWriteIfZero), .PCWrite(PCWrite),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
        .RegWrite(RegWrite), .MemToReg(MemToReg), .PCSource(PCSource), .RegDst(RegDst),
        .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .state_o(state_o), .instr_done(instr_done),
        .mem_timeout(mem_timeout), .trap(trap)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cur = 0;
    int waits = 0;
    bit needOp = 1'b1;
    int rdyMode = 0;
    int stuckLimit = 0;
    int path[$];
    int forced[$];
    int legal[$] = '{'h00, 'h23, 'h2b, 'h08, 'h0d, 'h18, 'h1c, 'h14, 'h1a, 'h19, 'h17, 'h0a,
                     'h0e, 'h0c, 'h16, 'h0f, 'h04, 'h05, 'h02, 'h03, 'h13, 'h12};

    wire [27:0] outsVec = {PCWriteIfNonZero, PCWriteIfZero, PCWrite, IorD, MemRead, MemWrite, IRWrite,
                           ALUSrcA, RegWrite, MemToReg, PCSource, RegDst, ALUOp, ALUSrcB,
                           instr_done, mem_timeout, trap};

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (model state %0d, t=%0t)", tag, obs, exp, cur, $time);
        end
    endtask

    // Control values each state must show, straight from the state table.
    function automatic logic [27:0] expOut(input int st, input bit rdy, input bit tmo);
        logic pnz, pz, pw, iord, mr, mw, irw, asa, rw, done, tr;
        logic [1:0] m2r, pcs, rd;
        logic [6:0] aop;
        logic [2:0] asb;
        {pnz, pz, pw, iord, mr, mw, irw, asa, rw, done, tr} = '0;
        m2r = 2'd0; pcs = 2'd0; rd = 2'd0; aop = 7'd0; asb = 3'd0;
        case (st)
            0:  begin mr = 1; asb = 1; irw = rdy; pw = rdy; end
            1:  asb = 4;
            2:  begin asa = 1; asb = 3; end
            3:  begin iord = 1; mr = 1; end
            4:  begin rw = 1; m2r = 1; done = 1; end
            5:  begin iord = 1; mw = 1; done = rdy; end
            6:  begin asa = 1; aop = 2; end
            7:  begin rw = 1; rd = 1; done = 1; end
            8:  begin asa = 1; asb = 3; aop = 2; end
            9:  begin rw = 1; done = 1; end
            10: begin asa = 1; asb = 2; aop = 2; end
            11: begin rw = 1; m2r = 2; done = 1; end
            12: begin asa = 1; aop = 1; pcs = 1; pz = 1; done = 1; end
            13: begin asa = 1; aop = 1; pcs = 1; pnz = 1; done = 1; end
            14: begin pw = 1; pcs = 2; done = 1; end
            15: begin pw = 1; pcs = 2; rw = 1; rd = 2; m2r = 3; done = 1; end
            16: begin pw = 1; pcs = 3; rw = 1; rd = 2; m2r = 3; done = 1; end
            17: begin pw = 1; pcs = 3; done = 1; end
            18: begin tr = 1; done = 1; end
            default: done = 0;
        endcase
        return {pnz, pz, pw, iord, mr, mw, irw, asa, rw, m2r, pcs, rd, aop, asb, done, tmo, tr};
    endfunction

    // Remaining states an instruction visits after DECODE.
    task automatic loadPath(input int op);
        path.delete();
        case (op)
            'h23: path = '{2, 3, 4};
            'h2b: path = '{2, 5};
            'h08, 'h0d, 'h18, 'h1c, 'h14, 'h1a, 'h19, 'h17, 'h0a, 'h0e: path = '{8, 9};
            'h0c, 'h16: path = '{10, 9};
            'h0f: path = '{11};
            'h04: path = '{12};
            'h05: path = '{13};
            'h02: path = '{14};
            'h03: path = '{15};
            'h13: path = '{16};
            'h12: path = '{17};
            'h00: path = '{6, 7};
`ifdef CTRL_ILLEGAL_TRAP_EN
            default: path = '{18};
`else
            default: path = '{6, 7};
`endif
        endcase
    endtask

    task automatic modelReset();
        cur = 0; waits = 0; needOp = 1'b1; path.delete();
    endtask

    task automatic step();
        bit rdy, tmo, isMem;
        @(negedge clk);
        if (needOp) begin
            if (forced.size() > 0) opCode = 6'(forced.pop_front());
            else if ($urandom_range(0, 1) == 0) opCode = 6'(legal[$urandom_range(0, legal.size() - 1)]);
            else opCode = 6'($urandom_range(0, 63));
            needOp = 1'b0;
        end
        isMem = (cur == 0) || (cur == 3) || (cur == 5);
        if (rdyMode == 0) rdy = ($urandom_range(0, 3) != 0);
        else rdy = (cur == 3 || cur == 5) ? (waits >= stuckLimit) : 1'b1;
        mem_ready = rdy;
        #1;
        tmo = isMem && !rdy && (waits == TMO);
        checkVal("state", {27'd0, state_o}, cur);
        checkVal("outs", {4'd0, outsVec}, {4'd0, expOut(cur, rdy, tmo)});
        if (isMem && !rdy) begin
            if (tmo) modelReset();
            else waits++;
        end else begin
            waits = 0;
            if (cur == 0) cur = 1;
            else begin
                if (cur == 1) loadPath(int'(opCode));
                if (path.size() > 0) cur = path.pop_front();
                else begin cur = 0; needOp = 1'b1; end
            end
        end
    endtask

    task automatic runOne(input int op);
        int n = 0;
        forced.push_back(op);
        do begin step(); n++; end while (cur != 0 && n < 100);
        if (cur != 0) checkVal("budget", cur, 0);
    endtask

    task automatic resetCheck();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        checkVal("rst_state", {27'd0, state_o}, 0);
        checkVal("rst_outs", {4'd0, outsVec}, {4'd0, expOut(0, 1'b0, 1'b0)});
        modelReset();
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; opCode = 6'd0; mem_ready = 1'b0;
        resetCheck();
        rdyMode = 1; stuckLimit = 0;
        runOne('h00);
        stuckLimit = 3;
        runOne('h23);
        stuckLimit = 99;
        runOne('h2b);
        stuckLimit = 0;
        runOne('h05);
        runOne('h03);
        runOne('h3f);
        runOne('h0f);
        runOne('h12);
        // Abandon a load that is waiting on memory.
        stuckLimit = 99;
        forced.push_back('h23);
        n = 0;
        do begin step(); n++; end while (cur != 3 && n < 20);
        if (cur != 3) checkVal("budget_ld", cur, 3);
        step(); step();
        resetCheck();
        stuckLimit = 0;
        runOne('h00);
        rdyMode = 0;
        for (int i = 0; i < 3000; i++) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
